// File: rtl/modulation_index_gen.sv
// modulation_index_gen: per-segment modulation index tracking SYS_TIME via serial-divide resync and incremental steps.
// Define MODULATION_INDEX_GEN_JUMP_RESYNC_EN to auto-resync on SYS_TIME jumps in RUN/CATCH_UP.
module modulation_index_gen #(
   parameter int NumSegment = 2,
   parameter int PendW      = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [63:0]                sys_time_i,
   input  logic                       update_settings_i,
   input  logic [NumSegment*15-1:0]   cycle_i,
   input  logic [NumSegment*16-1:0]   freq_div_i,
   output logic [NumSegment*15-1:0]   idx_o,
   output logic                       valid_o,
   output logic                       busy_o
);
   localparam logic [2:0] START    = 3'd0;
   localparam logic [2:0] RUN      = 3'd1;
   localparam logic [2:0] DIV_Q    = 3'd2;
   localparam logic [2:0] DIV_M    = 3'd3;
   localparam logic [2:0] CATCH_UP = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [63:0]      sys_q, t0_q, t0_d;
   logic [5:0]       bitcnt_q, bitcnt_d;
   logic [PendW-1:0] pending_q, pending_d;
   logic             valid_q, valid_d, busy_q, busy_d;
   logic             step, jump, latch_new, relatch, in_div;
   logic [PendW:0]   avail;
   logic [1:0]       n_apply;

   // {rem, idx} advanced by one SYS_TIME tick
   function automatic logic [30:0] step_f(input logic [30:0] s, input logic [15:0] d, input logic [14:0] c);
      return (s[30:15] == d - 16'd1) ? {16'd0, (s[14:0] == c) ? 15'd0 : s[14:0] + 15'd1}
                                     : {s[30:15] + 16'd1, s[14:0]};
   endfunction

   assign step      = sys_time_i == sys_q + 64'd1;
   assign in_div    = state_q == DIV_Q || state_q == DIV_M;
`ifdef MODULATION_INDEX_GEN_JUMP_RESYNC_EN
   assign jump      = (state_q == RUN || state_q == CATCH_UP) && sys_time_i != sys_q && !step;
`else
   assign jump      = 1'b0;
`endif
   assign latch_new = update_settings_i || state_q == START;
   assign relatch   = latch_new || jump || (in_div && step && pending_q == '1);
   assign avail     = {1'b0, pending_q} + {{PendW{1'b0}}, step};
   // the step arriving this cycle is absorbed together with the backlog
   assign n_apply   = relatch ? 2'd0 :
                      state_q == RUN ? {1'b0, step} :
                      state_q == CATCH_UP ? ((avail > (PendW+1)'(1)) ? 2'd2 : avail[1:0]) : 2'd0;

   always_comb begin
      state_d   = state_q;
      t0_d      = t0_q;
      bitcnt_d  = bitcnt_q;
      pending_d = pending_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      if (relatch) begin
         state_d   = DIV_Q;
         t0_d      = sys_time_i;
         bitcnt_d  = 6'd63;
         pending_d = '0;
         valid_d   = 1'b0;
         busy_d    = 1'b1;
      end else if (in_div) begin
         bitcnt_d  = bitcnt_q - 6'd1;
         pending_d = pending_q + PendW'(step);
         if (bitcnt_q == 6'd0) state_d = (state_q == DIV_Q) ? DIV_M : CATCH_UP;
      end else if (state_q == CATCH_UP) begin
         pending_d = PendW'(avail - (PendW+1)'(n_apply));
         if (avail == (PendW+1)'(n_apply)) begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= START;
         sys_q     <= '0;
         t0_q      <= '0;
         bitcnt_q  <= '0;
         pending_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sys_q     <= sys_time_i;
         t0_q      <= t0_d;
         bitcnt_q  <= bitcnt_d;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign valid_o = valid_q;
   assign busy_o  = busy_q;

   for (genvar g = 0; g < NumSegment; g++) begin : g_seg
      logic [14:0] cyc_q, idx_q, idx_d;
      logic [15:0] div_q, rem_q, rem_d, mrem_q, mrem_d, fdiv, modv, qsub, msub;
      logic [63:0] quo_q, quo_d;
      logic [16:0] qr2, mr2;
      logic        qge, mge;
      logic [30:0] s1, s2;
      assign fdiv = freq_div_i[g*16 +: 16];
      assign modv = {1'b0, cyc_q} + 16'd1;
      assign qr2  = {rem_q, t0_q[bitcnt_q]};
      assign qge  = qr2 >= {1'b0, div_q};
      assign qsub = 16'(qr2 - {1'b0, div_q});
      assign mr2  = {mrem_q, quo_q[bitcnt_q]};
      assign mge  = mr2 >= {1'b0, modv};
      assign msub = 16'(mr2 - {1'b0, modv});
      assign s1   = step_f({rem_q, idx_q}, div_q, cyc_q);
      assign s2   = step_f(s1, div_q, cyc_q);

      always_comb begin
         rem_d  = rem_q;
         idx_d  = idx_q;
         mrem_d = mrem_q;
         quo_d  = quo_q;
         if (relatch) begin
            rem_d  = '0;
            mrem_d = '0;
         end else if (state_q == DIV_Q) begin
            rem_d = qge ? qsub : qr2[15:0];
            quo_d = {quo_q[62:0], qge};
         end else if (state_q == DIV_M) begin
            mrem_d = mge ? msub : mr2[15:0];
            if (bitcnt_q == 6'd0) idx_d = mrem_d[14:0];
         end else if (n_apply == 2'd2) begin
            {rem_d, idx_d} = s2;
         end else if (n_apply == 2'd1) begin
            {rem_d, idx_d} = s1;
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cyc_q  <= '0;
            div_q  <= 16'd1;
            rem_q  <= '0;
            idx_q  <= '0;
            mrem_q <= '0;
            quo_q  <= '0;
         end else begin
            if (latch_new) begin
               cyc_q <= cycle_i[g*15 +: 15];
               div_q <= (fdiv == 16'd0) ? 16'd1 : fdiv;
            end
            rem_q  <= rem_d;
            idx_q  <= idx_d;
            mrem_q <= mrem_d;
            quo_q  <= quo_d;
         end
      end

      assign idx_o[g*15 +: 15] = idx_q;
   end
endmodule

// File: tb/tb_modulation_index_gen.sv
// tb_modulation_index_gen: directed checks of modulation_index_gen resync, tracking, rollover and reset behaviour.
module tb_modulation_index_gen;
   localparam int NS = 2;
   logic            clk = 1'b0, rst = 1'b1, upd = 1'b0;
   logic [63:0]     sys_time = 64'd0;
   logic [14:0]     cyc [NS];
   logic [15:0]     fd [NS];
   logic [NS*15-1:0] cyc_bus, idx_bus;
   logic [NS*16-1:0] fd_bus;
   logic            valid, busy;
   logic [14:0]     idx [NS];
   logic [63:0]     base;
   int              passed = 0, total = 0;
   bit              run_time = 1'b0;

   assign cyc_bus = {cyc[1], cyc[0]};
   assign fd_bus  = {fd[1], fd[0]};
   assign idx[0]  = idx_bus[14:0];
   assign idx[1]  = idx_bus[29:15];

   always #5 clk = ~clk;

   modulation_index_gen #(.NumSegment(NS), .PendW(8)) dut (
      .clk_i(clk), .rst_i(rst), .sys_time_i(sys_time), .update_settings_i(upd),
      .cycle_i(cyc_bus), .freq_div_i(fd_bus), .idx_o(idx_bus), .valid_o(valid), .busy_o(busy)
   );

   function automatic logic [63:0] model(input logic [63:0] t, input logic [15:0] d, input logic [14:0] c);
      logic [63:0] dd = (d == 16'd0) ? 64'd1 : {48'd0, d};
      return ((t / dd) % ({49'd0, c} + 64'd1));
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic adv();
      if (run_time) sys_time = sys_time + 64'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_update();
      upd = 1'b1;
      adv();
      upd = 1'b0;
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!valid && n < bound) begin
         adv();
         n++;
      end
      check("valid_within_bound", {63'd0, valid}, 64'd1);
   endtask

   task automatic track(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         adv();
         check({tag, "_valid"}, {63'd0, valid}, 64'd1);
         for (int s = 0; s < NS; s++) check(tag, {49'd0, idx[s]}, model(sys_time, fd[s], cyc[s]));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cyc[0] = 15'd3; fd[0] = 16'd10; cyc[1] = 15'd5; fd[1] = 16'd7;
      sys_time = 64'd1234;
      repeat (3) @(posedge clk);
      #1;
      check("rst_idx0", {49'd0, idx[0]}, 64'd0);
      check("rst_idx1", {49'd0, idx[1]}, 64'd0);
      check("rst_valid", {63'd0, valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b0;
      adv();
      check("start_busy", {63'd0, busy}, 64'd1);
      check("start_valid", {63'd0, valid}, 64'd0);
      repeat (128) adv();
      check("valid_not_early", {63'd0, valid}, 64'd0);
      adv();
      check("valid_at_130", {63'd0, valid}, 64'd1);
      check("busy_at_130", {63'd0, busy}, 64'd0);
      check("static_idx0", {49'd0, idx[0]}, 64'd3);
      check("static_idx1", {49'd0, idx[1]}, 64'd2);
      run_time = 1'b1;
      track(2000, "track");
      pulse_update();
      check("upd_busy", {63'd0, busy}, 64'd1);
      check("upd_valid", {63'd0, valid}, 64'd0);
      wait_valid(299);
      track(50, "retrack");
      run_time = 1'b0;
      fd[0] = 16'd0; cyc[0] = 15'd0; fd[1] = 16'd1; cyc[1] = 15'd32767;
      sys_time = 64'hFFFF_FFFF_FFFF_FFFB;
      pulse_update();
      wait_valid(300);
      check("roll_idx0", {49'd0, idx[0]}, 64'd0);
      check("roll_idx1", {49'd0, idx[1]}, 64'd32763);
      run_time = 1'b1;
      track(10, "rollover");
      run_time = 1'b0;
      fd[0] = 16'd10; cyc[0] = 15'd3; fd[1] = 16'd5; cyc[1] = 15'd2;
      sys_time = 64'd5000;
      pulse_update();
      repeat (39) adv();
      check("hold_idx0", {49'd0, idx[0]}, 64'd0);
      check("hold_idx1", {49'd0, idx[1]}, 64'd5);
      check("hold_busy", {63'd0, busy}, 64'd1);
      fd[0] = 16'd7;
      pulse_update();
      repeat (128) adv();
      check("redo_not_early", {63'd0, valid}, 64'd0);
      adv();
      check("redo_valid", {63'd0, valid}, 64'd1);
      check("redo_idx0_div7", {49'd0, idx[0]}, 64'd2);
      check("redo_idx1", {49'd0, idx[1]}, 64'd1);
      fd[0] = 16'd10; cyc[0] = 15'd3; fd[1] = 16'd3; cyc[1] = 15'd9;
      sys_time = 64'd100000;
      run_time = 1'b1;
      pulse_update();
      repeat (140) adv();
      check("catchup_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_idx0", {49'd0, idx[0]}, 64'd0);
      check("mid_rst_idx1", {49'd0, idx[1]}, 64'd0);
      check("mid_rst_valid", {63'd0, valid}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      adv();
      adv();
      rst = 1'b0;
      wait_valid(300);
      track(20, "post_reset");
      run_time = 1'b0;
      fd[1] = 16'd1;
      pulse_update();
      wait_valid(300);
      base = sys_time;
      sys_time = base + 64'd500;
      adv();
`ifdef MODULATION_INDEX_GEN_JUMP_RESYNC_EN
      check("jump_busy", {63'd0, busy}, 64'd1);
      wait_valid(300);
      for (int s = 0; s < NS; s++) check("jump_resync_idx", {49'd0, idx[s]}, model(sys_time, fd[s], cyc[s]));
`else
      check("jump_no_resync", {63'd0, busy}, 64'd0);
      check("jump_valid", {63'd0, valid}, 64'd1);
      for (int s = 0; s < NS; s++) check("jump_no_step", {49'd0, idx[s]}, model(base, fd[s], cyc[s]));
      for (int k = 1; k <= 2; k++) begin
         sys_time = sys_time + 64'd1;
         adv();
         for (int s = 0; s < NS; s++) check("after_jump_step", {49'd0, idx[s]}, model(base + 64'(k), fd[s], cyc[s]));
      end
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/modulation_index_gen.md
Name: modulation_index_gen

Overview:
- Producer of the per-segment modulation sample index consumed by the modulation swapchain as its SYNC_IDX input.
- Derives IDX[i] = floor(SYS_TIME / FREQ_DIV[i]) mod (CYCLE[i]+1) for every segment without a per-cycle 64-bit divider.
- Resynchronises with a multi-cycle serial divider, then tracks SYS_TIME incrementally.
- Sits between the system-time counter and the modulation swapchain/memory read address.

Parameters:
- NumSegment, 2, number of modulation segments, each tracked in parallel.
- PendW, 8, width of the pending-step counter used during resync.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- SYS_TIME  input  64  system time; advances by +1 per step.
- UPDATE_SETTINGS  input  1  single-cycle pulse: latch CYCLE/FREQ_DIV and resync.
- CYCLE[NumSegment]  input  15  last valid index per segment (period = CYCLE+1).
- FREQ_DIV[NumSegment]  input  16  SYS_TIME ticks per index step; a value of 0 is coerced to 1.
- IDX[NumSegment]  output  15  current index per segment.
- VALID  output  1  high while IDX tracks SYS_TIME exactly.
- BUSY  output  1  high during resync (DIV_Q, DIV_M, CATCH_UP).

Behaviour:
- Reset values: IDX=0, internal rem=0, VALID=0, BUSY=0, state=START, pending=0.
- START lasts 1 cycle after reset release and behaves as if UPDATE_SETTINGS were seen.
- Latch, on UPDATE_SETTINGS or START:
  - cyc_l[i] <= CYCLE[i], div_l[i] <= max(FREQ_DIV[i],1), t0 <= SYS_TIME.
  - pending <= 0, VALID <= 0, BUSY <= 1, bitcnt <= 63, state <= DIV_Q.
- Step detection: sys_q <= SYS_TIME every cycle; step = (SYS_TIME == sys_q+1).
- Step rule per segment:
  - If rem == div_l-1: rem <= 0 and IDX <= (IDX == cyc_l) ? 0 : IDX+1.
  - Otherwise: rem <= rem+1.
- States:
  - RUN: on step, apply one step. IDX after edge k equals f(SYS_TIME sampled at edge k), i.e. 1-cycle latency. VALID=1.
  - DIV_Q: 64-iteration restoring division t0 / div_l[i], all segments in parallel, one quotient bit per cycle, 17-bit partial remainder. After bitcnt==0: rem[i] <= remainder, q[i] <= quotient, bitcnt <= 63, state <= DIV_M.
  - DIV_M: 64-iteration restoring remainder of q[i] mod (cyc_l[i]+1), 16-bit divisor, quotient discarded. At end: IDX[i] <= remainder, state <= CATCH_UP.
  - CATCH_UP:
    - If pending >= 2, apply two steps per cycle (chained combinationally), else one.
    - Each cycle, pending <= pending - applied + step.
    - When pending reaches 0 (including a new step absorbed the same cycle): state <= RUN, VALID <= 1, BUSY <= 0.
- Pending counter:
  - Increments on each step while in DIV_Q/DIV_M.
  - Maximum is 129 (129 cycles of division), so 8 bits never overflow.
  - On saturation at all-ones, restart resync (defensive).
- IDX holds its last value during DIV_Q; it changes only at the end of DIV_M and during CATCH_UP.
- UPDATE_SETTINGS in any state, including mid-resync: re-latch and restart DIV_Q, pending cleared. It has priority over a step in the same cycle; that step is lost and t0 = SYS_TIME of that cycle covers it.
- Wrap-around cases:
  - cyc_l = 0 keeps IDX at 0.
  - div_l = 1 advances IDX every step.
  - SYS_TIME rollover from all-ones to 0 counts as a step (+1 mod 2^64).
- RST asserted mid-operation returns immediately to the reset values; START follows release.
- Nominal resync duration: 1 + 64 + 64 cycles of division plus about 129 cycles of catch-up.

Optional Feature:
- Macro: MODULATION_INDEX_GEN_JUMP_RESYNC_EN.
- Defined: in RUN or CATCH_UP, a SYS_TIME change that is neither 0 nor +1 (EtherCAT time correction) triggers an automatic resync, exactly as UPDATE_SETTINGS but with settings unchanged (the current latched values are kept).
- Undefined: such a change is ignored (no step) and no resync occurs.

Test Plan:
- Reset, FREQ_DIV=10, CYCLE=3, SYS_TIME=1234 held static -> after DIV_M, IDX=123 mod 4=3 and internal rem=4. VALID=1 once pending=0, 130 cycles after START.
- From the previous state, SYS_TIME +1 per cycle for 2000 cycles -> every cycle after VALID, IDX = floor(SYS_TIME_prev/10) mod 4. VALID returns high no later than 300 cycles after UPDATE_SETTINGS.
- Two segments: seg0 FREQ_DIV=0, CYCLE=0 and seg1 FREQ_DIV=1, CYCLE=32767, SYS_TIME starting at 2^64-5 and incrementing -> IDX[0] stays 0. IDX[1] = SYS_TIME mod 32768 across the 64-bit rollover.
- UPDATE_SETTINGS asserted again 40 cycles into DIV_Q with FREQ_DIV changed 10->7 -> pending clears, division restarts, final IDX matches divisor 7 and not 10.
- RST pulsed during CATCH_UP -> IDX=0, VALID=0 on the same edge. After release, full resync completes with correct IDX.
- With MODULATION_INDEX_GEN_JUMP_RESYNC_EN, SYS_TIME jumps +500 in RUN -> BUSY=1 next cycle and IDX is correct after resync. Without the macro, no resync occurs and IDX does not step on the jump.
